// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: CPU has priority, I/O loader wins after
// STARVE_MAX consecutive lost arbitrations.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_done,
    output logic [DATA_W-1:0] io_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IO  = 1'b1
    } owner_t;

    state_t             state;
    state_t             state_nxt;
    owner_t             owner;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [CNT_W-1:0]   starve_cnt;

    logic               arb_cycle;
    logic               io_win;
    logic               cpu_win;

    assign arb_cycle = (state == IDLE) || (state == RESP);
    assign io_win    = arb_cycle && io_req &&
                       (!cpu_req || (starve_cnt == CNT_MAX));
    assign cpu_win   = arb_cycle && cpu_req && !io_win;

    // State, owner, latched request and starvation counter
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cpu_win) begin
                owner     <= OWN_CPU;
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
            end else if (io_win) begin
                owner     <= OWN_IO;
                lat_we    <= io_we;
                lat_addr  <= io_addr;
                lat_wdata <= io_wdata;
            end
            if (io_win) begin
                starve_cnt <= '0;
            end else if (cpu_win && io_req && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            ACCESS:  state_nxt = RESP;
            default: state_nxt = (cpu_win || io_win) ? ACCESS : IDLE;
        endcase
    end

    // Address/data follow the latch, which only moves on a win,
    // so they hold their last value outside ACCESS.
    always_comb begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        cpu_gnt   = 1'b0;
        io_gnt    = 1'b0;
        cpu_done  = 1'b0;
        io_done   = 1'b0;
        cpu_rdata = '0;
        io_rdata  = '0;
        unique case (state)
            ACCESS: begin
                mem_write = lat_we;
                mem_read  = ~lat_we;
                cpu_gnt   = (owner == OWN_CPU);
                io_gnt    = (owner == OWN_IO);
            end
            RESP: begin
                cpu_done = (owner == OWN_CPU);
                io_done  = (owner == OWN_IO);
                if (!lat_we) begin
                    unique case (1'b1)
                        (owner == OWN_CPU): cpu_rdata = mem_rdata;
                        (owner == OWN_IO):  io_rdata  = mem_rdata;
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors push expected
// grant/done events, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    logic        clock;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_done;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        io_req, io_we, io_gnt, io_done;
    logic [15:0] io_addr, io_wdata, io_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)
    ) dut (
        .clock(clock), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_gnt(io_gnt), .io_done(io_done),
        .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: read data valid one cycle after mem_read
    logic [15:0] mem [0:1023];
    logic [15:0] rdq;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h010] = 16'hBEEF;
        rdq = 16'h0000;
    end
    always @(posedge clock) begin
        if (mem_write === 1'b1) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_read === 1'b1) rdq <= mem[mem_addr[9:0]];
    end
    assign mem_rdata = rdq;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct {
        bit io;
        bit done;
        int cyc;
        bit we;
        int addr;
        int data;
    } ev_t;
    ev_t q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(bit io, bit done, int c, bit we, int addr, int data);
        ev_t e;
        e.io = io; e.done = done; e.cyc = c;
        e.we = we; e.addr = addr; e.data = data;
        q.push_back(e);
    endfunction

    function automatic void take(bit io, bit done);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event io=%0d done=%0d want none (cycle %0d)",
                     io, done, cyc);
            return;
        end
        e = q.pop_front();
        chk("ev_port", 32'(io), 32'(e.io));
        chk("ev_kind", 32'(done), 32'(e.done));
        chk("ev_cycle", cyc, e.cyc);
        if (!done) begin
            chk("gnt_write", 32'(mem_write), 32'(e.we));
            chk("gnt_read", 32'(mem_read), 32'(!e.we));
            chk("gnt_addr", 32'(mem_addr), e.addr);
            if (e.we) chk("gnt_wdata", 32'(mem_wdata), e.data);
        end else begin
            chk("resp_strobes", 32'({mem_read, mem_write}), 0);
            chk("resp_addr_hold", 32'(mem_addr), e.addr);
            if (!e.we) begin
                chk("done_rdata", 32'(io ? io_rdata : cpu_rdata), e.data);
                chk("other_rdata", 32'(io ? cpu_rdata : io_rdata), 0);
            end
        end
    endfunction

    always @(negedge clock) begin
        if (started) begin
            logic inv_ok;
            inv_ok = !(cpu_gnt && io_gnt) && !(cpu_done && io_done) &&
                     !(mem_read && mem_write) && (dut.starve_cnt <= 4) &&
                     ((mem_read | mem_write) == (cpu_gnt | io_gnt)) &&
                     !((cpu_gnt | io_gnt) && (cpu_done | io_done));
            chk("invariant", 32'(inv_ok), 1);
            if (cpu_gnt || io_gnt) take(io_gnt, 1'b0);
            if (cpu_done || io_done) take(io_done, 1'b1);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int k;
        int peak;
        int n;
        bit is_io;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
        tick(2);
        started = 1'b1;

        chk("rst_outputs", 32'({cpu_gnt, cpu_done, io_gnt, io_done, mem_write, mem_read}), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_rdata", 32'({cpu_rdata, io_rdata}), 0);
        chk("rst_starve", 32'(dut.starve_cnt), 0);

        // CPU read in the release cycle itself
        rst = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        k = cyc;
        push(0, 0, k + 1, 0, 'h0010, 0);
        push(0, 1, k + 2, 0, 'h0010, 'hBEEF);
        tick(1);
        cpu_req = 0;
        tick(3);

        // I/O write alone
        io_req = 1; io_we = 1; io_addr = 16'h0200; io_wdata = 16'h1234;
        k = cyc;
        push(1, 0, k + 1, 1, 'h0200, 'h1234);
        push(1, 1, k + 2, 1, 'h0200, 0);
        tick(1);
        io_req = 0;
        tick(3);

        // CPU reads back the I/O write
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
        k = cyc;
        push(0, 0, k + 1, 0, 'h0200, 0);
        push(0, 1, k + 2, 0, 'h0200, 'h1234);
        tick(1);
        cpu_req = 0;
        tick(3);

        // Simultaneous, CPU drops req during ACCESS
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        io_req = 1; io_we = 1; io_addr = 16'h0400; io_wdata = 16'hA5A5;
        k = cyc;
        push(0, 0, k + 1, 0, 'h0010, 0);
        push(0, 1, k + 2, 0, 'h0010, 'hBEEF);
        push(1, 0, k + 3, 1, 'h0400, 'hA5A5);
        push(1, 1, k + 4, 1, 'h0400, 0);
        tick(1);
        cpu_req = 0;
        chk("starve_after_cpu_win", 32'(dut.starve_cnt), 1);
        tick(2);
        io_req = 0;
        tick(3);

        // Starvation: both held for 12 accesses
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        io_req = 1; io_we = 1; io_addr = 16'h0400; io_wdata = 16'h5A5A;
        k = cyc;
        for (int i = 0; i < 12; i++) begin
            is_io = (i == 4) || (i == 9);
            if (is_io) begin
                push(1, 0, k + 1 + 2 * i, 1, 'h0400, 'h5A5A);
                push(1, 1, k + 2 + 2 * i, 1, 'h0400, 0);
            end else begin
                push(0, 0, k + 1 + 2 * i, 0, 'h0010, 0);
                push(0, 1, k + 2 + 2 * i, 0, 'h0010, 'hBEEF);
            end
        end
        peak = 0;
        repeat (23) begin
            tick(1);
            if (int'(dut.starve_cnt) > peak) peak = int'(dut.starve_cnt);
        end
        cpu_req = 0;
        io_req = 0;
        chk("starve_peak", peak, 4);
        tick(3);

        // Reset during the ACCESS cycle of an I/O write
        io_req = 1; io_we = 1; io_addr = 16'h0600; io_wdata = 16'h7777;
        k = cyc;
        push(1, 0, k + 1, 1, 'h0600, 'h7777);
        tick(1);
        io_req = 0;
        rst = 1'b1;
        tick(1);
        chk("abort_mem_write", 32'(mem_write), 0);
        chk("abort_io_done", 32'(io_done), 0);
        chk("abort_state", 32'(int'(dut.state)), 0);
        chk("abort_starve", 32'(dut.starve_cnt), 0);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        tick(3);

        n = 0;
        while (q.size() > 0 && n < 20) begin
            tick(1);
            n++;
        end
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event io=%0d done=%0d want cycle %0d got none",
                     e.io, e.done, e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
